// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the MCP3002-class SPI sequencer.
// Frame phases, frame field lengths and counter sizing.
package adc_spi_pkg;

    localparam int ADC_RES   = 10;
    localparam int CFG_BITS  = 4;
    localparam int NULL_BITS = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_NULL,
        S_DATA,
        S_DONE
    } state_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/adc_ch_rr.sv
// Round-robin channel picker: next set mask bit after cur_ch, wrapping.
// An empty mask keeps the current channel.
module adc_ch_rr #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
    input  logic [CH_W-1:0]   cur_ch,
    input  logic [NUM_CH-1:0] mask,
    output logic [CH_W-1:0]   next_ch
);

    logic [2*NUM_CH-1:0] dbl;
    logic [NUM_CH-1:0]   rot;

    // rot[k] is the mask bit of channel (cur_ch + 1 + k) mod NUM_CH
    assign dbl = {mask, mask};
    assign rot = NUM_CH'(dbl >> (32'(cur_ch) + 32'd1));

    always_comb begin
        next_ch = cur_ch;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rot[k])
                next_ch = CH_W'((32'(cur_ch) + 1 + k) % NUM_CH);
        end
    end

endmodule

// File: rtl/adc_spi_sequencer.sv
// Continuous-conversion leader for an MCP3002-class ADC with channel rotation.
// Results leave through a valid/ready port with a sticky overrun flag.
import adc_spi_pkg::*;

module adc_spi_sequencer #(
    parameter int   DATA_BITS   = 10,
    parameter int   NUM_CH      = 2,
    parameter logic SGL_DIFF    = 1'b1,
    parameter int   IDLE_CYCLES = 2
) (
    input  logic                 CLKsample,
    input  logic                 RESET,
    input  logic                 enable,
    input  logic [NUM_CH-1:0]    ch_mask,
    input  logic                 Dout,
    output logic                 CS,
    output logic                 Din,
    output logic [DATA_BITS-1:0] sample_word,
    output logic                 sample_ch,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 busy,
    output logic                 overrun
);

    localparam int IW = cnt_width(IDLE_CYCLES);
    localparam int BW = cnt_width(ADC_RES);

    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);
    localparam logic [IW-1:0] IDLE_GO   = IW'(IDLE_CYCLES - 1);
    localparam logic [BW-1:0] CFG_LAST  = BW'(CFG_BITS - 1);
    localparam logic [BW-1:0] NULL_LAST = BW'(NULL_BITS - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    state_t               state;
    state_t               state_nx;
    logic [IW-1:0]        idle_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [ADC_RES-1:0]   shreg;
    logic                 frame_ch;
    logic                 pick_ch;

    adc_ch_rr #(
        .NUM_CH (NUM_CH),
        .CH_W   (1)
    ) u_rr (
        .cur_ch  (frame_ch),
        .mask    (ch_mask),
        .next_ch (pick_ch)
    );

    always_ff @(posedge CLKsample or negedge RESET) begin
        if (!RESET)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // The current IDLE cycle counts toward the gap, hence IDLE_GO.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:
                if (idle_cnt >= IDLE_GO && enable && |ch_mask)
                    state_nx = S_CFG;
            S_CFG:
                if (bit_cnt == CFG_LAST)
                    state_nx = S_NULL;
            S_NULL:
                if (bit_cnt == NULL_LAST)
                    state_nx = S_DATA;
            S_DATA:
                if (bit_cnt == DATA_LAST)
                    state_nx = S_DONE;
            S_DONE:
                state_nx = S_IDLE;
            default:
                state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        CS   = 1'b1;
        Din  = 1'b1;
        busy = 1'b0;
        unique case (state)
            S_CFG: begin
                CS   = 1'b0;
                busy = 1'b1;
                unique case (1'b1)
                    (bit_cnt == BW'(1)): Din = SGL_DIFF;
                    (bit_cnt == BW'(2)): Din = frame_ch;
                    default:             Din = 1'b1;
                endcase
            end
            S_NULL, S_DATA: begin
                CS   = 1'b0;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLKsample or negedge RESET) begin
        if (!RESET) begin
            idle_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            frame_ch <= 1'(NUM_CH - 1);
        end else begin
            bit_cnt <= (state_nx != state) ? '0 : bit_cnt + BW'(1);
            unique case (state)
                S_IDLE:
                    if (idle_cnt < IDLE_MAX)
                        idle_cnt <= idle_cnt + IW'(1);
                S_DONE:
                    idle_cnt <= IW'(1);
                default: ;
            endcase
            // Channel chosen from the mask as seen at frame start
            if (state == S_IDLE && state_nx == S_CFG)
                frame_ch <= pick_ch;
            if (state == S_DATA)
                shreg <= {shreg[ADC_RES-2:0], Dout};
        end
    end

    always_ff @(posedge CLKsample or negedge RESET) begin
        if (!RESET) begin
            sample_word  <= '0;
            sample_ch    <= 1'b0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (state == S_DONE) begin
            sample_word  <= shreg[DATA_BITS-1:0];
            sample_ch    <= frame_ch;
            sample_valid <= 1'b1;
            if (sample_valid && !sample_ready)
                overrun <= 1'b1;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// Directed bench for adc_spi_sequencer with behavioural MCP3002 models.
// Covers timing, rotation, truncation, handshake, overrun and reset.
module tb_adc_spi_sequencer;

    logic       CLKsample = 1'b0;
    logic       RESET = 1'b1;
    logic       enable = 1'b1;
    logic [1:0] ch_mask = 2'b01;
    logic       Dout = 1'b0;
    logic       CS;
    logic       Din;
    logic [9:0] sample_word;
    logic       sample_ch;
    logic       sample_valid;
    logic       sample_ready = 1'b0;
    logic       busy;
    logic       overrun;

    logic       Dout8 = 1'b0;
    logic       CS8;
    logic       Din8;
    logic [7:0] word8;
    logic       ch8;
    logic       valid8;
    logic       ready8 = 1'b1;
    logic [1:0] mask8 = 2'b01;
    logic       busy8;
    logic       overrun8;

    int checks = 0;
    int errors = 0;
    int n;
    int nf;

    logic [9:0] val0 = 10'h2A5;
    logic [9:0] val1 = 10'h3FF;
    logic [9:0] cur;
    logic [9:0] cur8 = 10'h2A5;
    int         pos = 0;
    int         len = 0;
    int         nfalls = 0;
    logic [3:0] din_bits = 4'h0;
    logic       odd = 1'b0;
    int         pos8 = 0;
    int         len8 = 0;

    adc_spi_sequencer dut (
        .CLKsample    (CLKsample),
        .RESET        (RESET),
        .enable       (enable),
        .ch_mask      (ch_mask),
        .Dout         (Dout),
        .CS           (CS),
        .Din          (Din),
        .sample_word  (sample_word),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .overrun      (overrun)
    );

    adc_spi_sequencer #(.DATA_BITS(8)) dut8 (
        .CLKsample    (CLKsample),
        .RESET        (RESET),
        .enable       (enable),
        .ch_mask      (mask8),
        .Dout         (Dout8),
        .CS           (CS8),
        .Din          (Din8),
        .sample_word  (word8),
        .sample_ch    (ch8),
        .sample_valid (valid8),
        .sample_ready (ready8),
        .busy         (busy8),
        .overrun      (overrun8)
    );

    always #5 CLKsample = ~CLKsample;

    // ADC model: drives each data bit on the falling edge before it is sampled
    always @(negedge CLKsample) begin
        if (CS) begin
            if (pos > 0) len = pos;
            pos  = 0;
            Dout = 1'b0;
        end else begin
            if (pos == 0) begin
                nfalls++;
                din_bits = 4'h0;
            end
            if (pos < 4) din_bits = {din_bits[2:0], Din};
            if (pos == 2) odd = Din;
            if (pos >= 5 && pos < 15) begin
                cur  = odd ? val1 : val0;
                Dout = cur[14-pos];
            end else begin
                Dout = 1'b0;
            end
            pos++;
        end
    end

    always @(negedge CLKsample) begin
        if (CS8) begin
            if (pos8 > 0) len8 = pos8;
            pos8  = 0;
            Dout8 = 1'b0;
        end else begin
            if (pos8 >= 5 && pos8 < 15) Dout8 = cur8[14-pos8];
            else Dout8 = 1'b0;
            pos8++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int k);
        repeat (k) begin
            @(posedge CLKsample);
            #1;
        end
    endtask

    task automatic wait_cs_fall(output int cnt);
        cnt = 0;
        while (CS !== 1'b0 && cnt < 100) begin
            @(posedge CLKsample);
            #1;
            cnt++;
        end
        if (CS !== 1'b0) begin
            checks++;
            errors++;
            $error("FAIL cs_fall_timeout observed=%0d expected<100", cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 RESET = 1'b0;
        repeat (3) @(negedge CLKsample);
        chk("rst_cs", CS, 1);
        chk("rst_din", Din, 1);
        chk("rst_word", sample_word, 0);
        chk("rst_ch", sample_ch, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        @(negedge CLKsample) RESET = 1'b1;

        // single channel, held result then overrun
        wait_cs_fall(n);
        chk("first_gap", n, 2);
        chk("busy_frame", busy, 1);
        cycles(16);
        chk("cfg_bits", din_bits, 4'b1101);
        chk("f1_word", sample_word, 10'h2A5);
        chk("f1_ch", sample_ch, 0);
        chk("f1_valid", sample_valid, 1);
        chk("f1_len", len, 15);
        chk("d8_word", word8, 8'hA9);
        chk("d8_len", len8, 13);
        chk("d8_ch", ch8, 0);
        val0 = 10'h155;
        wait_cs_fall(n);
        chk("period", 16 + n, 17);
        cycles(16);
        chk("ovr_word", sample_word, 10'h155);
        chk("ovr_valid", sample_valid, 1);
        chk("ovr_flag", overrun, 1);

        // two-channel rotation with ready held high
        @(negedge CLKsample);
        RESET = 1'b0;
        ch_mask = 2'b11;
        sample_ready = 1'b1;
        val0 = 10'h001;
        val1 = 10'h3FF;
        #1 chk("ovr_cleared", overrun, 0);
        @(negedge CLKsample) RESET = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_cs_fall(n);
            cycles(16);
            chk("rr_word", sample_word, (f % 2) ? 10'h3FF : 10'h001);
            chk("rr_ch", sample_ch, f % 2);
            chk("rr_odd", odd, f % 2);
        end
        chk("rr_no_ovr", overrun, 0);

        // acceptance on the same edge as a new result
        sample_ready = 1'b0;
        ch_mask = 2'b01;
        val0 = 10'h0F0;
        wait_cs_fall(n);
        cycles(15);
        sample_ready = 1'b1;
        cycles(1);
        chk("coin_word", sample_word, 10'h0F0);
        chk("coin_valid", sample_valid, 1);
        chk("coin_ovr", overrun, 0);
        cycles(1);
        chk("coin_clear", sample_valid, 0);

        // enable drop mid-frame: frame already running from the last edge
        val0 = 10'h3C3;
        cycles(2);
        enable = 1'b0;
        cycles(14);
        chk("en_word", sample_word, 10'h3C3);
        chk("en_valid", sample_valid, 1);
        nf = nfalls;
        cycles(40);
        chk("en_idle_falls", nfalls, nf);
        chk("en_idle_cs", CS, 1);

        enable = 1'b1;
        ch_mask = 2'b00;
        cycles(40);
        chk("mask0_falls", nfalls, nf);
        chk("mask0_busy", busy, 0);

        // reset during DATA bit 4
        ch_mask = 2'b01;
        val0 = 10'h2A5;
        wait_cs_fall(n);
        chk("sat_gap", n, 1);
        cycles(9);
        #2 RESET = 1'b0;
        #1;
        chk("mid_rst_cs", CS, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_word", sample_word, 0);
        chk("mid_rst_valid", sample_valid, 0);
        @(negedge CLKsample);
        @(negedge CLKsample) RESET = 1'b1;
        wait_cs_fall(n);
        chk("post_rst_gap", n, 2);
        cycles(16);
        chk("post_rst_word", sample_word, 10'h2A5);
        chk("post_rst_valid", sample_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_spi_sequencer.md
Name: adc_spi_sequencer

Overview:
Parametrised successor to the single-channel 8-bit MCP3002 leader. It runs continuous conversion frames on an MCP3002-class ADC and round-robins over a runtime channel mask. Resolution (1..10 bits), input mode (single-ended/differential) and CS idle time are all parameters. Results go downstream through a valid/ready handshake with a sticky overrun flag. The block sits between the SPI clock divider (which supplies CLKsample) and the sample buffer / logger.

Parameters:
DATA_BITS, 10, result bits kept, MSB-first truncation of the 10-bit ADC result; legal 1..10
NUM_CH, 2, number of ADC channels in rotation; legal 1..2
SGL_DIFF, 1, value driven in the SGL/DIFF config bit (1 = single-ended, 0 = pseudo-differential)
IDLE_CYCLES, 2, minimum CLKsample cycles with CS high between frames; legal 1..15 (2 cycles at 3.125 MHz gives ≥ 310 ns)

Ports:
CLKsample  input  1  SPI bit clock, also wired to the ADC CLK pin; all state updates on its rising edge
RESET  input  1  asynchronous, active-low reset
enable  input  1  1 = run frames back to back; 0 = finish the current frame, then idle
ch_mask  input  NUM_CH  channels in the rotation; sampled only at frame start
Dout  input  1  serial data from the ADC
CS  output  1  ADC chip select, active low
Din  output  1  serial config to the ADC
sample_word  output  DATA_BITS  latest result
sample_ch  output  1  channel of sample_word
sample_valid  output  1  result available; held high until accepted
sample_ready  input  1  downstream accepts when valid && ready
busy  output  1  frame in progress (CS low)
overrun  output  1  sticky: a new result was written while the previous one was still unaccepted

Behaviour:
- Reset (asynchronous assert, synchronous deassert by design): CS=1, Din=1, sample_word=0, sample_ch=0, sample_valid=0, busy=0, overrun=0, state=IDLE, idle counter=0, next channel = lowest set bit at first frame.
- States: IDLE, CFG, NULL, DATA, DONE.
- IDLE: CS=1, Din=1. The idle counter increments per cycle, saturating at IDLE_CYCLES. Go to CFG when counter ≥ IDLE_CYCLES, enable=1 and ch_mask≠0. Otherwise stay in IDLE.
- CFG, 4 cycles, CS=0, busy=1. Din sequence: 1 (start), SGL_DIFF, ODD = selected channel, 1 (MSBF).
- NULL, 1 cycle: CS=0, Din=1, Dout ignored.
- DATA, DATA_BITS cycles: CS=0, Din=1. On each rising edge, shift Dout into the LSB of the shift register (first bit received = MSB).
- DONE, 1 cycle:
  - CS=1, busy=0; sample_word ← shift register; sample_ch ← frame channel; sample_valid=1.
  - Set overrun if sample_valid was already 1 and not accepted this same cycle.
  - Advance the channel to the next set bit of ch_mask after the current one, wrapping to the lowest set bit.
  - Go to IDLE with the idle counter = 1 (the DONE cycle counts as CS-high time).
- Frame length = 4 + 1 + DATA_BITS cycles of CS low. With DATA_BITS < 10, CS rises early, which truncates the conversion (permitted by the ADC).
- Back-to-back period = 5 + DATA_BITS + IDLE_CYCLES cycles (17 with defaults).
- Handshake: sample_valid clears on the edge where valid && ready. If DONE coincides with acceptance, the new result loads, valid stays 1, and overrun is not set.
- enable falling mid-frame has no effect until DONE. ch_mask changes mid-frame apply at the next channel selection.
- ch_mask = 0 in IDLE: remain idle, no CS activity. A channel selected that is no longer in the mask is skipped on the next advance.
- NUM_CH=1: ODD=0 always, sample_ch=0.
- Reset mid-frame: CS rises immediately, the partial result is discarded, and the full IDLE_CYCLES gap is enforced after release.
- The block never drops CS low while sample_word is being written; the overrun flag is cleared only by RESET.

Decomposition:
- Package adc_spi_pkg:
  - state enum (IDLE/CFG/NULL/DATA/DONE)
  - constants ADC_RES=10, CFG_BITS=4, NULL_BITS=1
  - idle/bit counter width function
- One sub-module, adc_ch_rr: round-robin next-channel picker. Inputs are current channel and mask; output is the next channel. Combinational, reused by the later MCP3008 variant.

Test Plan:
- Reset release, enable=1, mask=2'b01, ADC model returns 10'h2A5 → CS high 2 cycles, then Din 1,1,0,1; sample_word=10'h2A5, sample_ch=0, valid=1 at cycle 16 after CS falls; period 17 cycles.
- mask=2'b11, ready=1 constant, ADC returns ch0=10'h001, ch1=10'h3FF → results alternate ch0/ch1 with ODD bit alternating 0/1; no overrun.
- DATA_BITS=8, ADC returns 10'h2A5 → sample_word=8'hA9; CS low for exactly 13 cycles.
- ready=0 for two frames → first result held, overrun=1 at second DONE, sample_word = second value; ready=1 with DONE on the same edge → overrun stays 0.
- RESET low during DATA bit 4 → CS=1 asynchronously, valid=0; after release, first CS fall ≥ IDLE_CYCLES later, full new frame.
- enable dropped during CFG → frame completes, one result; mask=0 → CS stays high indefinitely.
